bot_intr_scheduler: RTL and testbench

//  Interrupt scheduler for the single KCPSM6 interrupt input of nexys4_bot_if.

---
 rtl/bot_intr_scheduler.sv | 138 +++++++++++++
 tb/tb_bot_intr_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_intr_scheduler.sv
// bot_intr_scheduler: merges up to 8 rising-edge event sources into the single
// KCPSM6 interrupt line. Each event goes through request -> ack -> EOI.
// Firmware sees a mask register and a cause byte through the I/O port map.
module bot_intr_scheduler #(
   parameter int         NUM_SRC     = 4,
   parameter logic [7:0] MASK_PORT   = 8'h0F,
   parameter logic [7:0] CAUSE_PORT  = 8'h1F,
   parameter int         ACK_TIMEOUT = 1024
) (
   input  logic               sysclk,
   input  logic               sysreset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               write_strobe,
   input  logic               read_strobe,
   input  logic [7:0]         port_id,
   input  logic [7:0]         io_data_in,
   output logic [7:0]         rd_data,
   output logic               interrupt_request,
   input  logic               interrupt_ack,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] overrun
);

   localparam int CW = $clog2(ACK_TIMEOUT);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

   state_t             state, state_nxt;
   logic [NUM_SRC-1:0] src_q, mask, elig, edge_det, set, clr, ovr_set;
   logic [CW-1:0]      cnt;
   logic [2:0]         idx, sel_idx;
   logic               cause_valid, any_elig, timeout, eoi, ovr_clr;
   logic               req_set, take;
   logic [7:0]         cause;

   // Data bits above NUM_SRC are don't-care for the mask write
   logic unused_data;
   assign unused_data = ^io_data_in;

   assign edge_det = irq_src & ~src_q;
   assign set      = edge_det & mask;
   assign elig     = pending & mask;
   assign any_elig = |elig;
   assign timeout  = (cnt == CW'(ACK_TIMEOUT - 1));
   assign eoi      = write_strobe & (port_id == CAUSE_PORT);
   assign ovr_clr  = read_strobe & (port_id == CAUSE_PORT);

   // Lowest eligible index wins (source 0 = highest priority)
   always_comb begin
      sel_idx = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (elig[i]) sel_idx = 3'(i);
   end

   // The acked source leaves pending in the same cycle; a fresh edge that cycle re-arms it
   assign clr     = (take && any_elig) ? (NUM_SRC'(1) << sel_idx) : '0;
   assign ovr_set = set & pending & ~clr;

   // Cause byte is only meaningful while an event is in service
   assign cause = (state == SERVICE) ? {|overrun, 3'b000, cause_valid, idx} : 8'h00;

   // FSM state register
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) state <= IDLE;
      else          state <= state_nxt;
   end

   // FSM next-state: ack only matters in REQ, EOI only in SERVICE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_elig)      state_nxt = REQ;
         REQ:     if (interrupt_ack) state_nxt = SERVICE;
         SERVICE: if (eoi)           state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // FSM outputs: request pulses (initial and timeout re-pulse) and ack capture
   always_comb begin
      req_set = 1'b0;
      take    = 1'b0;
      case (state)
         IDLE:    req_set = any_elig;
         REQ: begin
            take    = interrupt_ack;
            req_set = ~interrupt_ack & timeout;
         end
         default: ;
      endcase
   end

   // Ack-timeout counter: cleared in IDLE and on each re-pulse, runs in REQ
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset)                     cnt <= '0;
      else if (state == IDLE)           cnt <= '0;
      else if (state == REQ) cnt <= timeout ? '0 : cnt + CW'(1);
   end

   // Event bookkeeping: edge detect, pending, sticky overrun, mask register
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         src_q   <= '0;
         pending <= '0;
         overrun <= '0;
         mask    <= '0;
      end else begin
         src_q   <= irq_src;
         pending <= (pending & ~clr) | set;
         overrun <= (ovr_clr ? '0 : overrun) | ovr_set;
         if (write_strobe && port_id == MASK_PORT) mask <= io_data_in[NUM_SRC-1:0];
      end
   end

   // Latch the serviced source at ack; cause_valid stays 0 if everything got masked
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         idx         <= 3'd0;
         cause_valid <= 1'b0;
      end else if (take) begin
         idx         <= sel_idx;
         cause_valid <= any_elig;
      end
   end

   // Registered request pulse and 1-cycle-latency read path
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         interrupt_request <= 1'b0;
         rd_data           <= 8'h00;
      end else begin
         interrupt_request <= req_set;
         rd_data           <= (port_id == MASK_PORT)  ? 8'(mask) :
                              (port_id == CAUSE_PORT) ? cause    : 8'h00;
      end
   end

endmodule

// File: tb/tb_bot_intr_scheduler.sv
// Directed bench for bot_intr_scheduler (ACK_TIMEOUT shortened to 8).
module tb_bot_intr_scheduler;

   localparam logic [7:0] MASK_PORT  = 8'h0F;
   localparam logic [7:0] CAUSE_PORT = 8'h1F;

   logic       sysclk = 1'b0;
   logic       sysreset = 1'b1;
   logic [3:0] irq_src = '0;
   logic       write_strobe = 1'b0, read_strobe = 1'b0, interrupt_ack = 1'b0;
   logic [7:0] port_id = 8'h00, io_data_in = 8'h00;
   logic [7:0] rd_data;
   logic       interrupt_request;
   logic [3:0] pending, overrun;

   int checks = 0;
   int errors = 0;

   bot_intr_scheduler #(
      .NUM_SRC(4), .MASK_PORT(MASK_PORT), .CAUSE_PORT(CAUSE_PORT), .ACK_TIMEOUT(8)
   ) dut (
      .sysclk(sysclk), .sysreset(sysreset), .irq_src(irq_src),
      .write_strobe(write_strobe), .read_strobe(read_strobe), .port_id(port_id),
      .io_data_in(io_data_in), .rd_data(rd_data), .interrupt_request(interrupt_request),
      .interrupt_ack(interrupt_ack), .pending(pending), .overrun(overrun)
   );

   always #5 sysclk = ~sysclk;

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic write_port(input logic [7:0] p, input logic [7:0] d);
      port_id = p; io_data_in = d; write_strobe = 1'b1;
      cyc(1);
      write_strobe = 1'b0;
   endtask

   task automatic pulse_src(input logic [3:0] b);
      irq_src = b;
      cyc(1);
      irq_src = '0;
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      cyc(1);
      interrupt_ack = 1'b0;
   endtask

   task automatic read_cause(output logic [7:0] v);
      port_id = CAUSE_PORT; read_strobe = 1'b1;
      cyc(1);
      read_strobe = 1'b0;
      v = rd_data;
   endtask

   // Waits (bounded) until interrupt_request is seen high
   task automatic wait_req(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cyc(1);
         if (interrupt_request) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [7:0] v;
      #2;
      checks++;
      if ({rd_data, interrupt_request, pending, overrun} !== 17'h0) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%h req=%b pend=%b ovr=%b required all 0",
                  rd_data, interrupt_request, pending, overrun);
      end
      cyc(2);
      sysreset = 1'b0;
      cyc(1);
      port_id = MASK_PORT;
      cyc(1);
      checks++;
      if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h required 00", rd_data); end
      read_cause(v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL reset_cause: got %h required 00", v); end
   endtask

   task automatic test_single();
      logic [7:0] v;
      write_port(MASK_PORT, 8'h0F);
      port_id = MASK_PORT;
      cyc(1);
      checks++;
      if (rd_data !== 8'h0F) begin errors++; $display("FAIL mask_read: got %h required 0F", rd_data); end
      pulse_src(4'b0100);
      checks++;
      if (pending !== 4'b0100 || interrupt_request !== 1'b0) begin
         errors++; $display("FAIL single_pend: got pend=%b req=%b required 0100/0", pending, interrupt_request);
      end
      cyc(1);
      checks++;
      if (interrupt_request !== 1'b1) begin errors++; $display("FAIL single_req: got %b required 1", interrupt_request); end
      cyc(1);
      checks++;
      if (interrupt_request !== 1'b0) begin errors++; $display("FAIL single_req_len: got %b required 0", interrupt_request); end
      ack();
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("FAIL single_clr: got %b required 0000", pending); end
      read_cause(v);
      checks++;
      if (v !== 8'h0A) begin errors++; $display("FAIL single_cause: got %h required 0A", v); end
      write_port(CAUSE_PORT, 8'hFF);
      read_cause(v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL single_eoi: got %h required 00", v); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      bit f;
      pulse_src(4'b1010);
      wait_req(f);
      checks++;
      if (!f) begin errors++; $display("FAIL b2b_req1: got no request required one"); end
      ack();
      read_cause(v);
      checks++;
      if (v !== 8'h09) begin errors++; $display("FAIL b2b_cause1: got %h required 09", v); end
      write_port(CAUSE_PORT, 8'h00);
      checks++;
      if (interrupt_request !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b required 0", interrupt_request); end
      cyc(1);
      checks++;
      if (interrupt_request !== 1'b1) begin errors++; $display("FAIL b2b_req2: got %b required 1", interrupt_request); end
      ack();
      read_cause(v);
      checks++;
      if (v !== 8'h0B) begin errors++; $display("FAIL b2b_cause2: got %h required 0B", v); end
      write_port(CAUSE_PORT, 8'h00);
   endtask

   task automatic test_mask();
      logic [7:0] v;
      bit f;
      bit seen;
      write_port(MASK_PORT, 8'h01);
      pulse_src(4'b0010);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (interrupt_request) seen = 1'b1;
      end
      checks++;
      if (seen || pending !== 4'b0000) begin
         errors++; $display("FAIL mask_drop: got req_seen=%b pend=%b required 0/0000", seen, pending);
      end
      pulse_src(4'b0001);
      write_port(MASK_PORT, 8'h00);
      checks++;
      if (pending !== 4'b0001) begin errors++; $display("FAIL mask_keep: got %b required 0001", pending); end
      ack();
      read_cause(v);
      checks++;
      if (v !== 8'h00 || pending !== 4'b0001) begin
         errors++; $display("FAIL mask_noelig: got cause=%h pend=%b required 00/0001", v, pending);
      end
      write_port(CAUSE_PORT, 8'h00);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         if (interrupt_request) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL mask_quiet: got request required none"); end
      write_port(MASK_PORT, 8'h01);
      wait_req(f);
      checks++;
      if (!f) begin errors++; $display("FAIL mask_unmask_req: got no request required one"); end
      ack();
      read_cause(v);
      checks++;
      if (v !== 8'h08 || pending !== 4'b0000) begin
         errors++; $display("FAIL mask_unmask_cause: got cause=%h pend=%b required 08/0000", v, pending);
      end
      write_port(CAUSE_PORT, 8'h00);
   endtask

   task automatic test_overrun();
      logic [7:0] v;
      write_port(MASK_PORT, 8'h0F);
      pulse_src(4'b0001);
      cyc(1);
      pulse_src(4'b0001);
      checks++;
      if (overrun !== 4'b0001 || pending !== 4'b0001) begin
         errors++; $display("FAIL ovr_set: got ovr=%b pend=%b required 0001/0001", overrun, pending);
      end
      ack();
      read_cause(v);
      checks++;
      if (v !== 8'h88) begin errors++; $display("FAIL ovr_cause: got %h required 88", v); end
      checks++;
      if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clear: got %b required 0000", overrun); end
      read_cause(v);
      checks++;
      if (v !== 8'h08) begin errors++; $display("FAIL ovr_cause2: got %h required 08", v); end
      write_port(CAUSE_PORT, 8'h00);
   endtask

   task automatic test_timeout();
      logic [7:0] v;
      bit f;
      int bad;
      pulse_src(4'b1000);
      wait_req(f);
      checks++;
      if (!f) begin errors++; $display("FAIL to_first: got no request required one"); end
      bad = 0;
      for (int k = 1; k <= 24; k++) begin
         cyc(1);
         if (interrupt_request !== ((k % 8) == 0)) begin
            bad++;
            $display("FAIL to_repulse: cycle %0d got req=%b required %b", k, interrupt_request, (k % 8) == 0);
         end
      end
      checks++;
      if (bad != 0) errors++;
      ack();
      read_cause(v);
      checks++;
      if (v !== 8'h0B) begin errors++; $display("FAIL to_cause: got %h required 0B", v); end
      write_port(CAUSE_PORT, 8'h00);
   endtask

   task automatic test_reset_in_service();
      bit f;
      bit seen;
      pulse_src(4'b0111);
      wait_req(f);
      ack();
      checks++;
      if (!f || pending !== 4'b0110) begin
         errors++; $display("FAIL rst_setup: got req=%b pend=%b required 1/0110", f, pending);
      end
      port_id = MASK_PORT;
      #2 sysreset = 1'b1;
      #1;
      checks++;
      if ({rd_data, interrupt_request, pending, overrun} !== 17'h0) begin
         errors++; $display("FAIL rst_async: got rd=%h req=%b pend=%b ovr=%b required all 0",
                           rd_data, interrupt_request, pending, overrun);
      end
      cyc(2);
      sysreset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (interrupt_request) seen = 1'b1;
      end
      checks++;
      if (seen || pending !== 4'b0000 || rd_data !== 8'h00) begin
         errors++; $display("FAIL rst_after: got req_seen=%b pend=%b mask_rd=%h required 0/0000/00", seen, pending, rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_mask();
      test_overrun();
      test_timeout();
      test_reset_in_service();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
